// File: rtl/fifo_uart_tx_pkg.sv
// Shared types and sizing helpers for the FIFO-fed UART transmitter.
package fifo_uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } tx_state_t;

  function automatic int CNT_W(input int clks_per_bit);
    return (clks_per_bit > 1) ? $clog2(clks_per_bit) : 1;
  endfunction

  function automatic int BIT_W(input int width);
    return $clog2(width + 1);
  endfunction

  // Even parity over a zero-extended word; padding zeros do not change the XOR.
  function automatic logic even_parity(input logic [63:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/fifo_uart_tx_if.sv
// FIFO read-side handshake between a synchronous FIFO and the UART transmitter.
interface fifo_uart_tx_if #(
  parameter int WIDTH = 8
);
  logic             fifo_valid;
  logic [WIDTH-1:0] fifo_data;
  logic             fifo_rd_en;

  modport master (output fifo_valid, output fifo_data, input fifo_rd_en);
  modport slave  (input fifo_valid, input fifo_data, output fifo_rd_en);
endinterface

// File: rtl/fifo_uart_tx_bit_timer.sv
// Free-running bit-period counter; restarts from zero whenever the FSM changes state.
module uart_bit_timer
  import fifo_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic nrst,
  input  logic clear,
  output logic bit_end
);
  localparam int            CW   = CNT_W(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_r;

  // cycle counter wrapping at the end of each bit period
  always_ff @(posedge clk) begin
    if (!nrst) begin
      cnt_r <= {CW{1'b0}};
    end else if (clear || (cnt_r == LAST)) begin
      cnt_r <= {CW{1'b0}};
    end else begin
      cnt_r <= cnt_r + CW'(1);
    end
  end

  assign bit_end = (cnt_r == LAST);
endmodule

// File: rtl/fifo_uart_tx.sv
// Drains a synchronous FIFO one word at a time and serialises each word as a UART frame
// (start, LSB-first data, optional even parity, one or two stop bits).
module fifo_uart_tx
  import fifo_uart_pkg::*;
#(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int PARITY_EN    = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic             clk,
  input  logic             nrst,
  fifo_uart_tx_if.slave    fifo,
  output logic             tx,
  output logic             busy,
  output logic             frame_done
);
  localparam int            BW        = BIT_W(WIDTH);
  localparam logic [BW-1:0] DATA_LAST = BW'(WIDTH - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  tx_state_t        state_r, state_s;
  logic [WIDTH-1:0] shift_r, shift_s;
  logic [BW-1:0]    bit_cnt_r;
  logic             parity_r;
  logic             tx_s;
  logic             bit_end_s;
  logic             clear_s;

  assign clear_s         = (state_s != state_r);
  assign fifo.fifo_rd_en = nrst && (state_r == ST_IDLE) && fifo.fifo_valid;

  uart_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk     (clk),
    .nrst    (nrst),
    .clear   (clear_s),
    .bit_end (bit_end_s)
  );

  // next-state decode
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (fifo.fifo_valid) state_s = ST_FETCH;
        else                 state_s = ST_IDLE;
      end
      ST_FETCH: state_s = ST_START;
      ST_START: begin
        if (bit_end_s) state_s = ST_DATA;
        else           state_s = ST_START;
      end
      ST_DATA: begin
        if (bit_end_s && (bit_cnt_r == DATA_LAST)) state_s = (PARITY_EN == 1) ? ST_PARITY : ST_STOP;
        else                                       state_s = ST_DATA;
      end
      ST_PARITY: begin
        if (bit_end_s) state_s = ST_STOP;
        else           state_s = ST_PARITY;
      end
      ST_STOP: begin
        if (bit_end_s && (bit_cnt_r == STOP_LAST)) state_s = ST_IDLE;
        else                                       state_s = ST_STOP;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // shift register and line value for the coming cycle; tx is registered from these
  always_comb begin
    shift_s = shift_r;
    if (state_r == ST_FETCH) begin
      shift_s = fifo.fifo_data;
    end else if ((state_r == ST_DATA) && bit_end_s) begin
      shift_s = shift_r >> 1;
    end else begin
      shift_s = shift_r;
    end

    tx_s = 1'b1;
    case (state_s)
      ST_START:  tx_s = 1'b0;
      ST_DATA:   tx_s = shift_s[0];
      ST_PARITY: tx_s = parity_r;
      default:   tx_s = 1'b1;
    endcase
  end

  // state, datapath and registered outputs
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_r    <= ST_IDLE;
      shift_r    <= {WIDTH{1'b0}};
      parity_r   <= 1'b0;
      tx         <= 1'b1;
      busy       <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      state_r    <= state_s;
      shift_r    <= shift_s;
      parity_r   <= (state_r == ST_FETCH) ? even_parity(64'(fifo.fifo_data)) : parity_r;
      tx         <= tx_s;
      busy       <= (state_s != ST_IDLE);
      frame_done <= (state_r == ST_STOP) && (state_s == ST_IDLE);
    end
  end

  // bit counter: data bits in DATA, stop bits in STOP
  always_ff @(posedge clk) begin
    if (!nrst) begin
      bit_cnt_r <= {BW{1'b0}};
    end else if (clear_s) begin
      bit_cnt_r <= {BW{1'b0}};
    end else if (bit_end_s && ((state_r == ST_DATA) || (state_r == ST_STOP))) begin
      bit_cnt_r <= bit_cnt_r + BW'(1);
    end else begin
      bit_cnt_r <= bit_cnt_r;
    end
  end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Two transmitter configurations fed by bench-side FIFOs, checked cycle by cycle against a frame-level model.
module tb_fifo_uart_tx;
  logic clk = 1'b0;
  logic nrst;
  always #5 clk = ~clk;

  fifo_uart_tx_if #(.WIDTH(8)) if_a ();
  fifo_uart_tx_if #(.WIDTH(8)) if_b ();
  logic tx_a, busy_a, done_a, tx_b, busy_b, done_b;

  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(16), .PARITY_EN(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .nrst(nrst), .fifo(if_a.slave), .tx(tx_a), .busy(busy_a), .frame_done(done_a));
  fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .STOP_BITS(2)) dut_b (
    .clk(clk), .nrst(nrst), .fifo(if_b.slave), .tx(tx_b), .busy(busy_b), .frame_done(done_b));

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  int       cpb   [2] = '{16, 4};
  int       par   [2] = '{0, 1};
  int       nstop [2] = '{1, 2};
  logic [7:0] fmem [2][256];
  int       head  [2] = '{0, 0};
  int       tail  [2] = '{0, 0};
  bit       active[2] = '{1'b0, 1'b0};
  int       pop_c [2] = '{0, 0};
  int       flen  [2] = '{0, 0};
  logic     fbits [2][16];
  int       pops  [2] = '{0, 0};
  logic     rd_rec[2];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    else             n_pass++;
  endtask

  function automatic int fcount(input int d);
    return tail[d] - head[d];
  endfunction

  function automatic bit model_idle(input int d);
    return !active[d] || (cyc > pop_c[d] + 2 + flen[d]);
  endfunction

  task automatic push(input int d, input logic [7:0] w);
    fmem[d][tail[d] % 256] = w;
    tail[d]++;
    if (d == 0) if_a.fifo_valid = 1'b1;
    else        if_b.fifo_valid = 1'b1;
  endtask

  task automatic build_frame(input int d, input logic [7:0] w);
    int k;
    fbits[d][0] = 1'b0;
    for (int i = 0; i < 8; i++) fbits[d][1 + i] = w[i];
    k = 9;
    if (par[d] == 1) begin
      fbits[d][k] = ^w;
      k++;
    end
    for (int s = 0; s < nstop[d]; s++) begin
      fbits[d][k] = 1'b1;
      k++;
    end
    flen[d] = k * cpb[d];
  endtask

  // One clock: check both DUTs at the negedge, then let the FIFOs react to the edge.
  task automatic step();
    logic o_tx, o_busy, o_done, o_rd, e_tx, e_busy, e_done, e_rd;
    int fend;
    string sfx;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      sfx    = (d == 0) ? "_a" : "_b";
      o_tx   = (d == 0) ? tx_a   : tx_b;
      o_busy = (d == 0) ? busy_a : busy_b;
      o_done = (d == 0) ? done_a : done_b;
      o_rd   = (d == 0) ? if_a.fifo_rd_en : if_b.fifo_rd_en;
      fend   = pop_c[d] + 2 + flen[d];
      e_tx   = 1'b1;
      if (active[d] && cyc >= pop_c[d] + 2 && cyc < fend) e_tx = fbits[d][(cyc - pop_c[d] - 2) / cpb[d]];
      e_busy = active[d] && cyc >= pop_c[d] + 1 && cyc < fend;
      e_done = active[d] && cyc == fend;
      e_rd   = nrst && (!active[d] || cyc >= fend) && (fcount(d) > 0);
      check_eq({"tx", sfx},    32'(o_tx),   32'(e_tx));
      check_eq({"busy", sfx},  32'(o_busy), 32'(e_busy));
      check_eq({"done", sfx},  32'(o_done), 32'(e_done));
      check_eq({"rd_en", sfx}, 32'(o_rd),   32'(e_rd));
      rd_rec[d] = o_rd;
      if (!nrst) begin
        active[d] = 1'b0;
      end else if (e_rd) begin
        build_frame(d, fmem[d][head[d] % 256]);
        active[d] = 1'b1;
        pop_c[d]  = cyc;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    for (int d = 0; d < 2; d++) begin
      if (rd_rec[d] === 1'b1 && fcount(d) > 0) begin
        if (d == 0) if_a.fifo_data = fmem[d][head[d] % 256];
        else        if_b.fifo_data = fmem[d][head[d] % 256];
        head[d]++;
        pops[d]++;
      end
    end
    if_a.fifo_valid = (fcount(0) > 0);
    if_b.fifo_valid = (fcount(1) > 0);
  endtask

  task automatic run_until_idle(input int max_cycles);
    for (int i = 0; i < max_cycles; i++) begin
      step();
      if (model_idle(0) && model_idle(1) && fcount(0) == 0 && fcount(1) == 0) return;
    end
    check_eq("idle_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int guard;
    nrst            = 1'b0;
    if_a.fifo_valid = 1'b0;
    if_a.fifo_data  = 8'h00;
    if_b.fifo_valid = 1'b0;
    if_b.fifo_data  = 8'h00;
    @(posedge clk);
    #1;
    step();
    step();
    nrst = 1'b1;

    // empty FIFO: line idle, no pops
    repeat (1000) step();

    // single words; B also exercises parity = 1
    push(0, 8'hA5);
    push(1, 8'h07);
    run_until_idle(400);
    push(1, 8'h03);
    run_until_idle(200);

    // back-to-back frames
    push(0, 8'h00); push(0, 8'hFF); push(0, 8'h55);
    push(1, 8'h00); push(1, 8'hFF); push(1, 8'h55);
    run_until_idle(1000);

    // reset during DATA bit 3 of DUT A, then a clean word
    push(0, 8'h3C);
    push(1, 8'h5A);
    guard = 0;
    while (!(active[0] && cyc == pop_c[0] + 2 + 16 * 4 + 5) && guard < 200) begin
      step();
      guard++;
    end
    check_eq("reset_point_reached", 32'(guard < 200), 32'd1);
    nrst = 1'b0;
    step();
    nrst = 1'b1;
    push(0, 8'hC3);
    push(1, 8'h96);
    run_until_idle(1000);

    // randomized traffic with occasional resets
    repeat (30) begin
      for (int d = 0; d < 2; d++)
        if ($urandom_range(0, 2) != 0) push(d, 8'($urandom));
      if ($urandom_range(0, 19) == 0) begin
        nrst = 1'b0;
        step();
        nrst = 1'b1;
      end
      repeat ($urandom_range(1, 80)) step();
    end
    run_until_idle(4000);

    check_eq("pops_a", 32'(pops[0]), 32'(tail[0]));
    check_eq("pops_b", 32'(pops[1]), 32'(tail[1]));
    repeat (5) step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
